// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline latch (PC + payload + control + valid) with stall, flush, bubble and a stall watchdog.
// Define PIPE_STAGE_PERF_EN to add saturating stall/flush performance counters.
module pipe_stage_reg #(
  parameter int PC_W        = 12,
  parameter int DATA_W      = 96,
  parameter int CTRL_W      = 9,
  parameter bit FLUSH_DATA  = 1'b1,
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              stall_timeout
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  stall_run_q, stall_run_d;
  logic              timeout_q, timeout_d;
  logic              stall_eff;

  // A stall that coincides with a flush is not a stall: the flush squashes immediately.
  assign stall_eff = stall & ~flush;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (FLUSH_DATA) begin
        pc_d   = '0;
        data_d = '0;
      end
    end else if (stall) begin
      valid_d = valid_q;
    end else if (bubble) begin
      valid_d = 1'b0;
      pc_d    = in_pc;
      data_d  = in_data;
      ctrl_d  = '0;
    end else begin
      valid_d = in_valid;
      pc_d    = in_pc;
      data_d  = in_data;
      ctrl_d  = in_valid ? in_ctrl : '0;
    end
  end

  always_comb begin
    stall_run_d = '0;
    timeout_d   = timeout_q;
    if (stall_eff) begin
      stall_run_d = (stall_run_q == CNT_MAX) ? stall_run_q : stall_run_q + CNT_ONE;
      if (32'(stall_run_d) >= 32'(STALL_LIMIT)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      data_q      <= '0;
      ctrl_q      <= '0;
      stall_run_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      stall_run_q <= stall_run_d;
      timeout_q   <= timeout_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_data      = data_q;
  assign out_ctrl      = ctrl_q;
  assign stall_timeout = timeout_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

  // Only flushes that actually kill a live instruction count as squashes.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_eff && perf_stall_q != CNT_MAX) perf_stall_d = perf_stall_q + CNT_ONE;
    if (flush && valid_q && perf_flush_q != CNT_MAX) perf_flush_d = perf_flush_q + CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
